fifo_rd_stream_adapter: RTL



---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_rd_stream_adapter_if.sv | 56 +++++
 rtl/rd_skid_buf.sv | 49 ++++
 rtl/fifo_rd_stream_adapter.sv | 82 ++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO-side definitions: output-adapter depth and the level type.
// No logic; latency n/a.
// Backpressure n/a. Also intended for the FIFO's own level reporting.
package fifo_pkg;

    // Words the read-stream adapter can hold, counting one read in flight.
    localparam int ADAPTER_DEPTH = 2;

    // Occupancy, 0..ADAPTER_DEPTH.
    typedef logic [1:0] level_t;

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// Bundle between the FIFO read port, the adapter and the stream consumer.
// Latency n/a (wires only).
// Backpressure: m_ready from the consumer; fifo_empty from the FIFO.
// Ports: fifo_r_data/fifo_empty/fifo_r_enable (FIFO side),
//        m_data/m_valid/m_ready (stream side), level.
//        With FIFO_RD_ADAPTER_STATS_EN defined, also xfer_count and stall_count.
interface fifo_rd_stream_adapter_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] fifo_r_data;
    logic             fifo_empty;
    logic             fifo_r_enable;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    level_t           level;
`ifdef FIFO_RD_ADAPTER_STATS_EN
    logic [31:0]      xfer_count;
    logic [31:0]      stall_count;
`endif

    // Adapter side.
    modport master (
        input  fifo_r_data,
        input  fifo_empty,
        output fifo_r_enable,
        output m_data,
        output m_valid,
        input  m_ready,
        output level
`ifdef FIFO_RD_ADAPTER_STATS_EN
        ,
        output xfer_count,
        output stall_count
`endif
    );

    // FIFO plus consumer side.
    modport slave (
        output fifo_r_data,
        output fifo_empty,
        input  fifo_r_enable,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  level
`ifdef FIFO_RD_ADAPTER_STATS_EN
        ,
        input  xfer_count,
        input  stall_count
`endif
    );

endinterface

// File: rtl/rd_skid_buf.sv
// 2-entry ordered output buffer (ring of two slots, head + count).
// Latency: a push is visible on rd_dat/level the cycle after its edge.
// Backpressure: none internally; the caller never pushes into a full buffer.
// Ports: clk, aresetn, push/push_dat (write), pop (consume head),
//        rd_dat (head word, registered), level (occupancy).
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output level_t           level
);

    logic [WIDTH-1:0] buf_q [ADAPTER_DEPTH];
    logic             head_q;
    level_t           count_q;
    logic             wr_idx;

    // Tail slot is head + count (mod 2), taken before this edge's pop.
    // When count=1 and a pop coincides with a push, the head slot drains
    // and the new word lands in the other slot, which becomes the new head.
    assign wr_idx = head_q ^ count_q[0];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < ADAPTER_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            head_q  <= 1'b0;
            count_q <= '0;
        end else begin
            if (push) begin
                buf_q[wr_idx] <= push_dat;
            end
            count_q <= count_q + level_t'(push) - level_t'(pop);
            head_q  <= head_q ^ pop;
        end
    end

    assign rd_dat = buf_q[head_q];
    assign level  = count_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the FIFO's enable/empty read port (1-cycle registered data) into a
// valid/ready stream. Latency: fifo_r_enable at T -> m_valid at T+2 when empty.
// Backpressure: m_data/m_valid hold while m_ready=0; reads stop at 2 words owned.
// Ports: clk, aresetn (async, active-low), bus (master modport).
// Optional: FIFO_RD_ADAPTER_STATS_EN adds xfer_count (wrapping) and
// stall_count (saturating) on the interface.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      aresetn,
    fifo_rd_stream_adapter_if.master  bus
);

    level_t           level_w;
    logic [WIDTH-1:0] head_dat;
    logic             m_valid_w;
    logic             pop;
    logic             issue;
    logic             inflight_q;
    logic [2:0]       occ_after_pop;

    assign m_valid_w = (level_w != '0);
    assign pop       = m_valid_w && bus.m_ready;

    // Words owned after this edge's pop, counting the read already in
    // flight. pop implies level>=1, so this cannot underflow. Keeping this
    // below the depth is what makes overflow impossible.
    assign occ_after_pop = 3'(level_w) + 3'(inflight_q) - 3'(pop);
    assign issue         = !bus.fifo_empty && (occ_after_pop < 3'(ADAPTER_DEPTH));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
        end
    end

    // FIFO data is valid the cycle after a granted read: capture it then.
    rd_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk      (clk),
        .aresetn  (aresetn),
        .push     (inflight_q),
        .push_dat (bus.fifo_r_data),
        .pop      (pop),
        .rd_dat   (head_dat),
        .level    (level_w)
    );

    assign bus.fifo_r_enable = issue;
    assign bus.m_valid       = m_valid_w;
    assign bus.m_data        = head_dat;
    assign bus.level         = level_w;

`ifdef FIFO_RD_ADAPTER_STATS_EN
    logic [31:0] xfer_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            if (pop) begin
                xfer_q <= xfer_q + 32'd1;
            end
            if (m_valid_w && !bus.m_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign bus.xfer_count  = xfer_q;
    assign bus.stall_count = stall_q;
`endif

endmodule
